// File: rtl/wb_arbiter_if.sv
// Writeback bus bundle: ALU result, load response, register-file write port and queue occupancy.
// The arbiter takes the slave side; the producer/observer takes the master side.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef GPRS_COUNT
`define GPRS_COUNT 32
`endif

interface wb_arbiter_if #(
    parameter int N        = `XLEN,
    parameter int GPRS     = `GPRS_COUNT,
    parameter int LQ_DEPTH = 4
);
    localparam int AW = $clog2(GPRS);
    localparam int CW = $clog2(LQ_DEPTH + 1);

    logic          alu_valid;
    logic [AW-1:0] alu_rd;
    logic [N-1:0]  alu_data;
    logic          ld_valid;
    logic          ld_ready;
    logic [AW-1:0] ld_rd;
    logic [2:0]    ld_funct3;
    logic [1:0]    ld_byte_off;
    logic [N-1:0]  ld_data;
    logic          we3;
    logic [AW-1:0] addr3;
    logic [N-1:0]  wd3;
    logic [CW-1:0] lq_count;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_valid, ld_rd, ld_funct3, ld_byte_off, ld_data,
        input  ld_ready, we3, addr3, wd3, lq_count
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_valid, ld_rd, ld_funct3, ld_byte_off, ld_data,
        output ld_ready, we3, addr3, wd3, lq_count
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results win every cycle; extended load responses queue and drain in idle slots.
// Optional macro WB_PERF_CNT_EN adds retired-write and load-stall counters.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef GPRS_COUNT
`define GPRS_COUNT 32
`endif

module wb_arbiter #(
    parameter int N        = `XLEN,
    parameter int GPRS     = `GPRS_COUNT,
    parameter int LQ_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    wb_arbiter_if.slave   bus
`ifdef WB_PERF_CNT_EN
    ,
    output logic [31:0]   wb_retired_cnt,
    output logic [31:0]   wb_ld_stall_cnt
`endif
);
    localparam int AW = $clog2(GPRS);
    localparam int CW = $clog2(LQ_DEPTH + 1);
    localparam int PW = $clog2(LQ_DEPTH);

    logic [N-1:0]  lq_data_q [LQ_DEPTH];
    logic [AW-1:0] lq_rd_q   [LQ_DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          we3_q, we3_d;
    logic [AW-1:0] addr3_q, addr3_d;
    logic [N-1:0]  wd3_q, wd3_d;

    logic          ready;
    logic          store;
    logic          pop;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [N-1:0]  ext_data;

    assign ld_byte = bus.ld_data[{bus.ld_byte_off, 3'b000} +: 8];
    assign ld_half = bus.ld_data[{bus.ld_byte_off[1], 4'b0000} +: 16];

    always_comb begin
        ext_data = bus.ld_data;
        case (bus.ld_funct3)
            3'b000:  ext_data = {{(N-8){ld_byte[7]}}, ld_byte};
            3'b100:  ext_data = {{(N-8){1'b0}}, ld_byte};
            3'b001:  ext_data = {{(N-16){ld_half[15]}}, ld_half};
            3'b101:  ext_data = {{(N-16){1'b0}}, ld_half};
            default: ext_data = bus.ld_data;
        endcase
    end

    // A full queue refuses loads even when it pops this cycle.
    always_comb begin
        ready = (count_q != CW'(LQ_DEPTH));
        store = bus.ld_valid && ready && (bus.ld_rd != '0);
        pop   = !bus.alu_valid && (count_q != '0);

        we3_d   = 1'b0;
        addr3_d = addr3_q;
        wd3_d   = wd3_q;
        if (bus.alu_valid) begin
            if (bus.alu_rd != '0) begin
                we3_d   = 1'b1;
                addr3_d = bus.alu_rd;
                wd3_d   = bus.alu_data;
            end
        end else if (pop) begin
            we3_d   = 1'b1;
            addr3_d = lq_rd_q[rd_ptr_q];
            wd3_d   = lq_data_q[rd_ptr_q];
        end

        count_d = count_q;
        if (store && !pop)
            count_d = count_q + CW'(1);
        else if (pop && !store)
            count_d = count_q - CW'(1);

        wr_ptr_d = store ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop   ? rd_ptr_q + PW'(1) : rd_ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we3_q    <= 1'b0;
            addr3_q  <= '0;
            wd3_q    <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            we3_q    <= we3_d;
            addr3_q  <= addr3_d;
            wd3_q    <= wd3_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage needs no reset: only slots between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (store) begin
            lq_data_q[wr_ptr_q] <= ext_data;
            lq_rd_q[wr_ptr_q]   <= bus.ld_rd;
        end
    end

    assign bus.ld_ready = ready;
    assign bus.we3      = we3_q;
    assign bus.addr3    = addr3_q;
    assign bus.wd3      = wd3_q;
    assign bus.lq_count = count_q;

`ifdef WB_PERF_CNT_EN
    logic [31:0] retired_q, stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            if (we3_q)
                retired_q <= retired_q + 32'd1;
            if (bus.ld_valid && !ready)
                stall_q <= stall_q + 32'd1;
        end
    end

    assign wb_retired_cnt  = retired_q;
    assign wb_ld_stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: queue-based reference model, directed scenarios, random traffic.
module tb_wb_arbiter;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   wb_arbiter_if #(.N(32), .GPRS(32), .LQ_DEPTH(DEPTH)) bus ();

`ifdef WB_PERF_CNT_EN
   logic [31:0] ret_cnt, stall_cnt;
`endif

   wb_arbiter #(.N(32), .GPRS(32), .LQ_DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef WB_PERF_CNT_EN
      ,
      .wb_retired_cnt  (ret_cnt),
      .wb_ld_stall_cnt (stall_cnt)
`endif
   );

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] d;
   } ent_t;

   ent_t        q[$];
   bit          m_we;
   logic [4:0]  m_addr;
   logic [31:0] m_wd;
   int unsigned m_ret, m_stall;
   int          n_checks = 0;
   int          n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ext(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
      int unsigned b, h;
      b = (w >> (8 * off)) & 32'hFF;
      h = (w >> (16 * off[1])) & 32'hFFFF;
      case (f3)
         3'd0:    return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
         3'd4:    return b;
         3'd1:    return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
         3'd5:    return h;
         default: return w;
      endcase
   endfunction

   task automatic check_outputs();
      chk("we3", bus.we3, m_we);
      chk("addr3", bus.addr3, m_addr);
      chk("wd3", bus.wd3, m_wd);
      chk("lq_count", bus.lq_count, q.size());
`ifdef WB_PERF_CNT_EN
      chk("retired_cnt", ret_cnt, m_ret);
      chk("stall_cnt", stall_cnt, m_stall);
`endif
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic cycle(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                        input bit lv, input logic [4:0] lrd, input logic [2:0] f3,
                        input logic [1:0] off, input logic [31:0] ld);
      bit   rdy;
      ent_t e;
      check_outputs();
      bus.alu_valid = av; bus.alu_rd = ard; bus.alu_data = ad;
      bus.ld_valid = lv; bus.ld_rd = lrd; bus.ld_funct3 = f3;
      bus.ld_byte_off = off; bus.ld_data = ld;
      #1;
      rdy = (q.size() != DEPTH);
      chk("ld_ready", bus.ld_ready, rdy);
      if (m_we) m_ret++;
      if (lv && !rdy) m_stall++;
      if (av) begin
         m_we = (ard != 0);
         if (ard != 0) begin m_addr = ard; m_wd = ad; end
      end else if (q.size() > 0) begin
         e = q.pop_front();
         m_we = 1'b1; m_addr = e.rd; m_wd = e.d;
      end else begin
         m_we = 1'b0;
      end
      if (lv && rdy && lrd != 0) q.push_back('{rd: lrd, d: ext(f3, off, ld)});
      @(negedge clk);
   endtask

   task automatic idle();
      cycle(0, 5'd0, 32'd0, 0, 5'd0, 3'd0, 2'd0, 32'd0);
   endtask

   task automatic model_clear();
      q.delete();
      m_we = 1'b0; m_addr = '0; m_wd = '0; m_ret = 0; m_stall = 0;
   endtask

   initial begin
      int unsigned s0;
      bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
      bus.ld_valid = 0; bus.ld_rd = 0; bus.ld_funct3 = 0; bus.ld_byte_off = 0; bus.ld_data = 0;
      model_clear();
      repeat (3) @(negedge clk);
      chk("reset we3", bus.we3, 0);
      chk("reset lq_count", bus.lq_count, 0);
      chk("reset ld_ready", bus.ld_ready, 1);
      rst_n = 1'b1;

      idle();
      cycle(1, 5'd5, 32'hDEAD_BEEF, 0, 5'd0, 3'd0, 2'd0, 32'd0);
      chk("alu we3", bus.we3, 1);
      chk("alu addr3", bus.addr3, 5);
      chk("alu wd3", bus.wd3, 32'hDEAD_BEEF);
      cycle(1, 5'd0, 32'h1111_2222, 0, 5'd0, 3'd0, 2'd0, 32'd0);
      chk("alu rd0 we3", bus.we3, 0);

      cycle(0, 5'd0, 32'd0, 1, 5'd7, 3'd0, 2'd2, 32'h0080_0000);
      chk("lb queued", bus.lq_count, 1);
      chk("lb not yet", bus.we3, 0);
      idle();
      chk("lb we3", bus.we3, 1);
      chk("lb addr3", bus.addr3, 7);
      chk("lb wd3", bus.wd3, 32'hFFFF_FF80);
      cycle(0, 5'd0, 32'd0, 1, 5'd8, 3'd5, 2'd2, 32'h8001_0000);
      idle();
      chk("lhu wd3", bus.wd3, 32'h0000_8001);
      cycle(0, 5'd0, 32'd0, 1, 5'd9, 3'd2, 2'd3, 32'h1234_5678);
      idle();
      chk("lw wd3", bus.wd3, 32'h1234_5678);
      chk("lw addr3", bus.addr3, 9);

      idle();
`ifdef WB_PERF_CNT_EN
      s0 = stall_cnt;
`else
      s0 = 0;
`endif
      for (int i = 0; i < 6; i++) begin
         chk("fill ready", bus.ld_ready, (i < DEPTH) ? 1 : 0);
         cycle(1, 5'(20 + i), 32'(i), 1, 5'(10 + i), 3'd2, 2'd0, 32'hA000_0000 + 32'(i));
      end
      chk("fill count", bus.lq_count, 4);
      chk("fill ready low", bus.ld_ready, 0);
`ifdef WB_PERF_CNT_EN
      chk("fill stalls", stall_cnt - s0, 2);
`endif
      for (int j = 0; j < 4; j++) begin
         idle();
         chk("drain we3", bus.we3, 1);
         chk("drain addr3", bus.addr3, 10 + j);
         chk("drain wd3", bus.wd3, 32'hA000_0000 + 32'(j));
      end
      idle();
      chk("drained we3", bus.we3, 0);

      cycle(0, 5'd0, 32'd0, 1, 5'd0, 3'd2, 2'd0, 32'hFFFF_FFFF);
      chk("rd0 count", bus.lq_count, 0);
      idle();
      chk("rd0 no write", bus.we3, 0);

      for (int i = 0; i < 3; i++)
         cycle(1, 5'd3, 32'h5, 1, 5'(11 + i), 3'd2, 2'd0, 32'hBEEF_0000);
      check_outputs();
      bus.alu_valid = 0; bus.ld_valid = 0;
      rst_n = 1'b0;
      #1;
      chk("midreset count", bus.lq_count, 0);
      chk("midreset we3", bus.we3, 0);
      chk("midreset ready", bus.ld_ready, 1);
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         idle();
         chk("post reset no write", bus.we3, 0);
      end

      for (int i = 0; i < 3000; i++) begin
         cycle(($urandom_range(0, 99) < 45), 5'($urandom_range(0, 31)), $urandom,
               ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)),
               2'($urandom_range(0, 3)), $urandom);
      end
      for (int i = 0; i < 6; i++) idle();
      check_outputs();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
